fb_write_arbiter: RTL

- Shares the single framebuffer BRAM write port among NUM_CORES ray-marcher cores using round-robin arbitration.
- Owns double buffering: cores always write the back bank, while the display pixel-fetch path reads the front bank.
- Counts completed pixels, waits for the vsync edge after a full frame, swaps banks, then pulses frame start to the cores.
- Sits between the ray-marcher cores, the framebuffer BRAM and the VGA timing generator.

---
 rtl/fb_write_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing one framebuffer write port among ray-marcher cores, with double buffering.
// Optional macro FB_DROP_COUNT_EN adds drop_count_out: count of vsync edges seen before a frame completed.
module fb_write_arbiter #(
    parameter int NUM_CORES   = 4,
    parameter int ADDR_BITS   = 17,
    parameter int DATA_BITS   = 4,
    parameter int PIXEL_COUNT = 76800
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic [NUM_CORES-1:0]           core_valid_in,
    input  logic [NUM_CORES*ADDR_BITS-1:0] core_addr_in,
    input  logic [NUM_CORES*DATA_BITS-1:0] core_data_in,
    output logic [NUM_CORES-1:0]           core_ready_out,
    input  logic                           vsync_in,
    output logic                           wr_en_out,
    output logic [ADDR_BITS:0]             wr_addr_out,
    output logic [DATA_BITS-1:0]           wr_data_out,
    output logic                           front_bank_out,
    output logic                           frame_start_out,
    output logic [15:0]                    frame_count_out
`ifdef FB_DROP_COUNT_EN
    ,
    output logic [15:0]                    drop_count_out
`endif
);

    localparam int PTR_BITS = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_BITS = $clog2(PIXEL_COUNT + 1);
    localparam logic [CNT_BITS-1:0] LAST_PIXEL = CNT_BITS'(PIXEL_COUNT - 1);
    localparam logic [PTR_BITS-1:0] LAST_CORE  = PTR_BITS'(NUM_CORES - 1);

    typedef enum logic [1:0] {
        KICK       = 2'd0,
        RENDER     = 2'd1,
        WAIT_VSYNC = 2'd2,
        SWAP       = 2'd3
    } state_t;

    state_t                state;
    logic [PTR_BITS-1:0]   rr_ptr;
    logic [CNT_BITS-1:0]   pixel_cnt;
    logic                  vsync_q;
    logic                  vsync_edge;
    logic                  transfer;
    logic [PTR_BITS-1:0]   grant_idx;
    logic [ADDR_BITS-1:0]  sel_addr;
    logic [DATA_BITS-1:0]  sel_data;

    // Handshake: a core's pixel moves when core_valid_in[i] && core_ready_out[i] in the same cycle;
    // a core holding valid keeps addr/data stable until it sees ready.
    always_comb begin
        transfer  = 1'b0;
        grant_idx = '0;
        if (state == RENDER) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (!transfer && core_valid_in[i] && (i >= int'(rr_ptr))) begin
                    transfer  = 1'b1;
                    grant_idx = PTR_BITS'(i);
                end
            end
            // Nothing at or above the pointer: wrap and search from core 0.
            for (int i = 0; i < NUM_CORES; i++) begin
                if (!transfer && core_valid_in[i]) begin
                    transfer  = 1'b1;
                    grant_idx = PTR_BITS'(i);
                end
            end
        end
    end

    always_comb begin
        core_ready_out = '0;
        if (transfer) begin
            core_ready_out[grant_idx] = 1'b1;
        end
    end

    assign sel_addr   = core_addr_in[int'(grant_idx)*ADDR_BITS +: ADDR_BITS];
    assign sel_data   = core_data_in[int'(grant_idx)*DATA_BITS +: DATA_BITS];
    assign vsync_edge = vsync_q & ~vsync_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= KICK;
            rr_ptr          <= '0;
            pixel_cnt       <= '0;
            vsync_q         <= 1'b1;
            wr_en_out       <= 1'b0;
            wr_addr_out     <= '0;
            wr_data_out     <= '0;
            front_bank_out  <= 1'b0;
            frame_start_out <= 1'b0;
            frame_count_out <= '0;
`ifdef FB_DROP_COUNT_EN
            drop_count_out  <= '0;
`endif
        end else begin
            vsync_q         <= vsync_in;
            wr_en_out       <= transfer;
            frame_start_out <= 1'b0;
            // Cores always write the back bank, i.e. the one the display is not reading.
            if (transfer) begin
                wr_addr_out <= {~front_bank_out, sel_addr};
                wr_data_out <= sel_data;
                rr_ptr      <= (grant_idx == LAST_CORE) ? '0 : grant_idx + 1'b1;
                pixel_cnt   <= pixel_cnt + 1'b1;
            end
`ifdef FB_DROP_COUNT_EN
            if (vsync_edge && (state == KICK || state == RENDER) && drop_count_out != 16'hFFFF) begin
                drop_count_out <= drop_count_out + 16'd1;
            end
`endif
            case (state)
                KICK: begin
                    frame_start_out <= 1'b1;
                    state           <= RENDER;
                end
                RENDER: begin
                    if (transfer && pixel_cnt == LAST_PIXEL) begin
                        state <= WAIT_VSYNC;
                    end
                end
                WAIT_VSYNC: begin
                    if (vsync_edge) begin
                        state <= SWAP;
                    end
                end
                SWAP: begin
                    front_bank_out  <= ~front_bank_out;
                    frame_count_out <= frame_count_out + 16'd1;
                    pixel_cnt       <= '0;
                    state           <= KICK;
                end
                default: state <= KICK;
            endcase
        end
    end

endmodule
